stopwatch_ctrl: RTL and testbench
=================================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter CLK_PER_MS, default 16, I_CLK cycles per millisecond (16 kHz clock).
REQ-002 Parameter DEB_CYCLES, default 160, cycles a button must be stable to be accepted (10 ms).
REQ-003 I_CLK  in  1  sole clock, rising edge.
REQ-004 I_RSTN  in  1  asynchronous, active-low reset.
REQ-005 I_BTN_SS  in  1  raw start/stop button, active high, asynchronous.
REQ-006 I_BTN_CLR  in  1  raw clear/lap button, active high, asynchronous.
REQ-007 I_TIMER_MS  in  10  live millisecond count from timer_counter, 0..999.
REQ-008 I_TIMER_SEC  in  6  live second count from timer_counter, 0..59.
REQ-009 O_EN_1MS  out  1  one-cycle 1 ms tick to timer_counter.
REQ-010 O_START_EN  out  1  counting enable to timer_counter.
REQ-011 O_CLEAR_EN  out  1  one-cycle clear pulse to timer_counter.
REQ-012 O_DISP_MS  out  10  displayed milliseconds.
REQ-013 O_DISP_SEC  out  6  displayed seconds.
REQ-014 O_STATE  out  2  FSM state: IDLE=0, RUN=1, STOP=2, LAP=3.
REQ-015 O_OVF  out  1  overflow flag (see Configuration).

Function
REQ-016 Each button SHALL pass a 2-flop synchronizer, then a debouncer: the debounced level changes only after the synchronized level differs from it for DEB_CYCLES consecutive cycles; any mismatch gap restarts the count.
REQ-017 A debounced 0->1 transition SHALL produce exactly one press pulse, in the cycle after the level changes; releases produce nothing.
REQ-018 FSM transitions SHALL be registered on the cycle after the press pulse.
REQ-019 IDLE: SS -> RUN; CLR ignored.
REQ-020 RUN: SS -> STOP; CLR -> LAP.
REQ-021 LAP: CLR -> RUN; SS -> STOP.
REQ-022 STOP: SS -> RUN; CLR -> IDLE, with O_CLEAR_EN high for exactly the transition cycle.
REQ-023 SS and CLR pulses in the same cycle: SS SHALL take priority and CLR is discarded.
REQ-024 O_START_EN SHALL be 1 exactly while state is RUN or LAP.
REQ-025 Prescaler 0..CLK_PER_MS-1 SHALL advance only while O_START_EN=1; O_EN_1MS high for the one cycle where prescaler = CLK_PER_MS-1, prescaler then wraps to 0.
REQ-026 Prescaler SHALL hold its value in STOP (partial ms preserved) and clear to 0 with O_CLEAR_EN.
REQ-027 In IDLE, RUN, STOP, O_DISP_* SHALL register I_TIMER_* each cycle (one-cycle latency).
REQ-028 On the RUN->LAP transition O_DISP_* SHALL capture I_TIMER_* and hold it throughout LAP; leaving LAP restores live tracking.
REQ-029 Buttons held continuously SHALL not repeat.

Reset
REQ-030 While I_RSTN=0: state IDLE; all outputs 0; prescaler, debounce counters, synchronizer and debounced levels 0.
REQ-031 Reset asserted mid-RUN SHALL stop O_EN_1MS immediately; after release, the block waits in IDLE for a new SS press.
REQ-032 A button held high through reset release SHALL register a press after DEB_CYCLES plus synchronizer latency.

Configuration
REQ-033 Macro STOPWATCH_CTRL_AUTOSTOP_EN defined: in RUN or LAP, when O_EN_1MS=1 with I_TIMER_SEC=59 and I_TIMER_MS=999, the FSM SHALL go to STOP next cycle and set O_OVF; O_OVF stays set until the STOP->IDLE clear.
REQ-034 Macro undefined: O_OVF tied 0; the count wraps per timer_counter with no FSM action.

Verification
REQ-035 Reset, SS held 160 cycles -> O_STATE=1 and O_START_EN=1 within 164 cycles; first O_EN_1MS 16 cycles after O_START_EN rises, then every 16 cycles.
REQ-036 SS bouncing (high 50, low 5, high 200 cycles) -> exactly one transition IDLE->RUN.
REQ-037 RUN, counter at 1.234 s, CLR press -> O_STATE=3, O_DISP shows 1 s/234 ms while I_TIMER_MS advances; CLR again -> display tracks live.
REQ-038 RUN, SS press, then CLR press -> STOP then IDLE; O_CLEAR_EN one cycle; prescaler 0; O_EN_1MS stays 0.
REQ-039 SS and CLR pulses coincide in RUN -> STOP only, no LAP, no clear.
REQ-040 With STOPWATCH_CTRL_AUTOSTOP_EN, I_TIMER at 59 s/999 ms plus tick -> O_STATE=2, O_OVF=1; without the macro -> stays RUN, O_OVF=0.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control block: synchronizes and debounces the start/stop and
// clear/lap buttons, runs the IDLE/RUN/STOP/LAP state machine, generates the
// 1 ms tick for timer_counter and drives the (optionally frozen) display.
// Optional feature macro: STOPWATCH_CTRL_AUTOSTOP_EN -- when defined, the
// stopwatch stops itself and raises O_OVF when 59 s / 999 ms is about to wrap.
module stopwatch_ctrl #(
  parameter int CLK_PER_MS = 16,
  parameter int DEB_CYCLES = 160
) (
  input  logic       I_CLK,
  input  logic       I_RSTN,
  input  logic       I_BTN_SS,
  input  logic       I_BTN_CLR,
  input  logic [9:0] I_TIMER_MS,
  input  logic [5:0] I_TIMER_SEC,
  output logic       O_EN_1MS,
  output logic       O_START_EN,
  output logic       O_CLEAR_EN,
  output logic [9:0] O_DISP_MS,
  output logic [5:0] O_DISP_SEC,
  output logic [1:0] O_STATE,
  output logic       O_OVF
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2,
    ST_LAP  = 2'd3
  } state_t;

  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_MS - 1);

  // Index 0 is start/stop, index 1 is clear/lap.
  logic [1:0]    btn_raw_s;
  logic [1:0]    meta_r;
  logic [1:0]    sync_r;
  logic [1:0]    deb_r;
  logic [1:0]    deb_d_r;
  logic [1:0]    press_r;
  logic [DW-1:0] deb_cnt_r [2];

  state_t        state_r;
  state_t        next_state_s;
  logic          clear_s;
  logic          ovf_set_s;
  logic          autostop_s;
  logic          press_ss_s;
  logic          press_clr_s;

  logic [PW-1:0] presc_r;
  logic          en_1ms_r;
  logic          start_en_r;
  logic          clear_en_r;
  logic          ovf_r;
  logic [9:0]    disp_ms_r;
  logic [5:0]    disp_sec_r;

  assign btn_raw_s   = {I_BTN_CLR, I_BTN_SS};
  assign press_ss_s  = press_r[0];
  assign press_clr_s = press_r[1];

`ifdef STOPWATCH_CTRL_AUTOSTOP_EN
  // The last tick before 59.999 wraps stops the watch instead of wrapping.
  assign autostop_s = en_1ms_r && (I_TIMER_SEC == 6'd59) && (I_TIMER_MS == 10'd999);
`else
  assign autostop_s = 1'b0;
`endif

  // Two-flop synchronizer for both raw buttons.
  always_ff @(posedge I_CLK or negedge I_RSTN) begin
    if (!I_RSTN) begin
      meta_r <= 2'b00;
      sync_r <= 2'b00;
    end else begin
      meta_r <= btn_raw_s;
      sync_r <= meta_r;
    end
  end

  // Debouncer: accept a new level only after DEB_CYCLES consecutive mismatches.
  always_ff @(posedge I_CLK or negedge I_RSTN) begin
    if (!I_RSTN) begin
      deb_r <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        deb_cnt_r[i] <= {DW{1'b0}};
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync_r[i] != deb_r[i]) begin
          if (deb_cnt_r[i] == DEB_LAST) begin
            deb_r[i]     <= sync_r[i];
            deb_cnt_r[i] <= {DW{1'b0}};
          end else begin
            deb_cnt_r[i] <= deb_cnt_r[i] + DW'(1);
          end
        end else begin
          deb_cnt_r[i] <= {DW{1'b0}};
        end
      end
    end
  end

  // One press pulse per debounced rising edge; releases are ignored.
  always_ff @(posedge I_CLK or negedge I_RSTN) begin
    if (!I_RSTN) begin
      deb_d_r <= 2'b00;
      press_r <= 2'b00;
    end else begin
      deb_d_r <= deb_r;
      press_r <= deb_r & ~deb_d_r;
    end
  end

  // Next-state logic; start/stop wins over clear/lap when both press together.
  always_comb begin
    next_state_s = state_r;
    clear_s      = 1'b0;
    ovf_set_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (press_ss_s) next_state_s = ST_RUN;
        else            next_state_s = ST_IDLE;
      end
      ST_RUN: begin
        if (autostop_s) begin
          next_state_s = ST_STOP;
          ovf_set_s    = 1'b1;
        end else if (press_ss_s) begin
          next_state_s = ST_STOP;
        end else if (press_clr_s) begin
          next_state_s = ST_LAP;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_LAP: begin
        if (autostop_s) begin
          next_state_s = ST_STOP;
          ovf_set_s    = 1'b1;
        end else if (press_ss_s) begin
          next_state_s = ST_STOP;
        end else if (press_clr_s) begin
          next_state_s = ST_RUN;
        end else begin
          next_state_s = ST_LAP;
        end
      end
      ST_STOP: begin
        if (press_ss_s) begin
          next_state_s = ST_RUN;
        end else if (press_clr_s) begin
          next_state_s = ST_IDLE;
          clear_s      = 1'b1;
        end else begin
          next_state_s = ST_STOP;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // State register with start enable and clear pulse aligned to the state.
  always_ff @(posedge I_CLK or negedge I_RSTN) begin
    if (!I_RSTN) begin
      state_r    <= ST_IDLE;
      start_en_r <= 1'b0;
      clear_en_r <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      start_en_r <= (next_state_s == ST_RUN) || (next_state_s == ST_LAP);
      clear_en_r <= clear_s;
    end
  end

  // Millisecond prescaler: runs while enabled, holds in STOP, zeroed by clear.
  always_ff @(posedge I_CLK or negedge I_RSTN) begin
    if (!I_RSTN) begin
      presc_r  <= {PW{1'b0}};
      en_1ms_r <= 1'b0;
    end else begin
      en_1ms_r <= start_en_r && (presc_r == PRESC_LAST);
      if (clear_s) begin
        presc_r <= {PW{1'b0}};
      end else if (start_en_r) begin
        if (presc_r == PRESC_LAST) presc_r <= {PW{1'b0}};
        else                       presc_r <= presc_r + PW'(1);
      end else begin
        presc_r <= presc_r;
      end
    end
  end

  // Overflow flag: set on auto-stop, kept until the STOP->IDLE clear.
  always_ff @(posedge I_CLK or negedge I_RSTN) begin
    if (!I_RSTN) begin
      ovf_r <= 1'b0;
    end else begin
`ifdef STOPWATCH_CTRL_AUTOSTOP_EN
      if (clear_s)        ovf_r <= 1'b0;
      else if (ovf_set_s) ovf_r <= 1'b1;
      else                ovf_r <= ovf_r;
`else
      ovf_r <= 1'b0;
`endif
    end
  end

  // Display tracks the live count except while frozen in LAP.
  always_ff @(posedge I_CLK or negedge I_RSTN) begin
    if (!I_RSTN) begin
      disp_ms_r  <= 10'd0;
      disp_sec_r <= 6'd0;
    end else if (state_r != ST_LAP) begin
      disp_ms_r  <= I_TIMER_MS;
      disp_sec_r <= I_TIMER_SEC;
    end else begin
      disp_ms_r  <= disp_ms_r;
      disp_sec_r <= disp_sec_r;
    end
  end

  assign O_EN_1MS   = en_1ms_r;
  assign O_START_EN = start_en_r;
  assign O_CLEAR_EN = clear_en_r;
  assign O_DISP_MS  = disp_ms_r;
  assign O_DISP_SEC = disp_sec_r;
  assign O_STATE    = state_r;
  assign O_OVF      = ovf_r;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: a table of button presses with
// expected states, hand-written corner-case sequences, and a random phase,
// all compared every cycle against a window-based behavioural model.
module tb_stopwatch_ctrl;

  localparam int CPM     = 16;
  localparam int DEB     = 160;
  localparam int ST_IDLE = 0;
  localparam int ST_RUN  = 1;
  localparam int ST_STOP = 2;
  localparam int ST_LAP  = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       btn_ss = 1'b0;
  logic       btn_clr = 1'b0;
  logic [9:0] tmr_ms = 10'd0;
  logic [5:0] tmr_sec = 6'd0;
  logic       en_1ms, start_en, clear_en, ovf;
  logic [9:0] disp_ms;
  logic [5:0] disp_sec;
  logic [1:0] state;

  int errors = 0;
  int checks = 0;

  int trans_cnt = 0;
  int clr_seen  = 0;
  int tick_seen = 0;
  logic [1:0] prev_state_obs = 2'd0;

  stopwatch_ctrl #(.CLK_PER_MS(CPM), .DEB_CYCLES(DEB)) dut (
    .I_CLK(clk), .I_RSTN(rst_n), .I_BTN_SS(btn_ss), .I_BTN_CLR(btn_clr),
    .I_TIMER_MS(tmr_ms), .I_TIMER_SEC(tmr_sec), .O_EN_1MS(en_1ms),
    .O_START_EN(start_en), .O_CLEAR_EN(clear_en), .O_DISP_MS(disp_ms),
    .O_DISP_SEC(disp_sec), .O_STATE(state), .O_OVF(ovf)
  );

  always #5 clk = ~clk;

  // Behavioural reference model.
  // Transition table indexed [state][event], event 0 = none, 1 = clear, 2 = start/stop.
  int next_tab [4][3] = '{'{0, 0, 1}, '{1, 3, 2}, '{2, 0, 1}, '{3, 1, 2}};
  bit [1:0]     m_rawd [2];
  bit [DEB-1:0] m_win  [2];
  bit           m_lvl   [2];
  bit           m_lvl_p [2];
  bit           m_press [2];
  int m_st, m_run, m_dms, m_dsec;
  bit m_en, m_tick, m_clr, m_ovf;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_rawd[i] = '0; m_win[i] = '0; m_lvl[i] = 0; m_lvl_p[i] = 0; m_press[i] = 0;
    end
    m_st = ST_IDLE; m_run = 0; m_dms = 0; m_dsec = 0;
    m_en = 0; m_tick = 0; m_clr = 0; m_ovf = 0;
  endtask

  // Advance the model across one rising edge given the inputs seen before it.
  task automatic model_edge(input bit ss_raw, input bit clr_raw, input int tms, input int tsec);
    int ev, nst, nrun;
    bit nclr, nset, ntick, used;
    bit raw [2];
    bit nlvl [2];
    bit npress [2];
    raw[0] = ss_raw; raw[1] = clr_raw;
    ev   = m_press[0] ? 2 : (m_press[1] ? 1 : 0);
    nst  = next_tab[m_st][ev];
    nclr = (m_st == ST_STOP) && (ev == 1);
    nset = 0;
`ifdef STOPWATCH_CTRL_AUTOSTOP_EN
    if ((m_st == ST_RUN || m_st == ST_LAP) && m_tick && tsec == 59 && tms == 999) begin
      nst  = ST_STOP;
      nset = 1;
    end
`endif
    ntick = m_en && ((m_run % CPM) == CPM - 1);
    nrun  = nclr ? 0 : (m_en ? m_run + 1 : m_run);
    if (m_st != ST_LAP) begin
      m_dms = tms; m_dsec = tsec;
    end
    if (nclr) m_ovf = 0;
    else if (nset) m_ovf = 1;
    for (int i = 0; i < 2; i++) begin
      npress[i] = m_lvl[i] & ~m_lvl_p[i];
      used      = m_rawd[i][1];
      m_rawd[i] = {m_rawd[i][0], raw[i]};
      m_win[i]  = {m_win[i][DEB-2:0], used};
      nlvl[i]   = m_lvl[i];
      if (m_win[i] == (m_lvl[i] ? {DEB{1'b0}} : {DEB{1'b1}})) nlvl[i] = ~m_lvl[i];
    end
    for (int i = 0; i < 2; i++) begin
      m_lvl_p[i] = m_lvl[i]; m_lvl[i] = nlvl[i]; m_press[i] = npress[i];
    end
    m_st = nst; m_en = (nst == ST_RUN) || (nst == ST_LAP);
    m_tick = ntick; m_clr = nclr; m_run = nrun;
  endtask

  task automatic check_eq(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic check_range(input string name, input int got, input int lo, input int hi);
    checks++;
    if (got < lo || got > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, got, lo, hi);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [21:0] got, exp;
    got = {state, start_en, en_1ms, clear_en, ovf, disp_ms, disp_sec};
    exp = {2'(m_st), m_en, m_tick, m_clr, m_ovf, 10'(m_dms), 6'(m_dsec)};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got st=%0d en=%0b tick=%0b clr=%0b ovf=%0b disp=%0d.%0d, expected st=%0d en=%0b tick=%0b clr=%0b ovf=%0b disp=%0d.%0d",
               tag, $time, state, start_en, en_1ms, clear_en, ovf, disp_sec, disp_ms,
               m_st, m_en, m_tick, m_clr, m_ovf, m_dsec, m_dms);
    end
  endtask

  task automatic check_zero(input string tag);
    checks++;
    if ({state, start_en, en_1ms, clear_en, ovf, disp_ms, disp_sec} !== 22'd0) begin
      errors++;
      $display("FAIL %s: got st=%0d en=%0b tick=%0b clr=%0b ovf=%0b disp=%0d.%0d, expected all zero",
               tag, state, start_en, en_1ms, clear_en, ovf, disp_sec, disp_ms);
    end
  endtask

  // One clock: model the edge, then compare 1 ns after it.
  task automatic cyc(input string tag);
    @(posedge clk);
    model_edge(btn_ss, btn_clr, int'(tmr_ms), int'(tmr_sec));
    #1;
    check_outputs(tag);
    if (state !== prev_state_obs) trans_cnt++;
    prev_state_obs = state;
    if (clear_en === 1'b1) clr_seen++;
    if (en_1ms === 1'b1) tick_seen++;
  endtask

  task automatic hold(input int n, input string tag);
    repeat (n) cyc(tag);
  endtask

  task automatic press(input bit ss, input bit clr, input string tag);
    btn_ss = ss; btn_clr = clr;
    hold(170, tag);
    btn_ss = 1'b0; btn_clr = 1'b0;
    hold(170, tag);
  endtask

  // Called 1 ns after an edge; asserts reset between edges.
  task automatic apply_reset(input int ncyc);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_zero("reset_async");
    repeat (ncyc) begin
      @(posedge clk);
      #1;
      check_zero("reset_hold");
    end
    prev_state_obs = 2'd0;
    rst_n = 1'b1;
  endtask

  // Cycles until start enable rises, bounded.
  task automatic wait_start(output int n);
    n = 0;
    while (start_en !== 1'b1 && n < 300) begin
      cyc("wait_start");
      n++;
    end
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      cyc("wait_tick");
      n++;
    end while (en_1ms !== 1'b1 && n < 100);
  endtask

  typedef struct {
    bit ss;
    bit clr;
    int exp_state;
    bit exp_start;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int n;
    int dh, dl;
    int v;
    vecs[0]  = '{1'b0, 1'b1, ST_IDLE, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, ST_RUN,  1'b1};
    vecs[2]  = '{1'b0, 1'b1, ST_LAP,  1'b1};
    vecs[3]  = '{1'b0, 1'b1, ST_RUN,  1'b1};
    vecs[4]  = '{1'b0, 1'b1, ST_LAP,  1'b1};
    vecs[5]  = '{1'b1, 1'b0, ST_STOP, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, ST_RUN,  1'b1};
    vecs[7]  = '{1'b1, 1'b0, ST_STOP, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, ST_IDLE, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, ST_RUN,  1'b1};
    vecs[10] = '{1'b1, 1'b1, ST_STOP, 1'b0};
    vecs[11] = '{1'b0, 1'b1, ST_IDLE, 1'b0};

    // Power-on reset.
    model_reset();
    #1 rst_n = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check_zero("por");
    end
    rst_n = 1'b1;

    // Table of button presses from IDLE.
    for (int i = 0; i < 12; i++) begin
      press(vecs[i].ss, vecs[i].clr, "table");
      check_eq($sformatf("table_state[%0d]", i), int'(state), vecs[i].exp_state);
      check_eq($sformatf("table_start[%0d]", i), int'(start_en), int'(vecs[i].exp_start));
    end

    // Start latency and tick cadence, button held (no repeat).
    apply_reset(3);
    btn_ss = 1'b1;
    wait_start(n);
    check_range("start_latency", n, 160, 164);
    check_eq("start_state", int'(state), ST_RUN);
    wait_tick(n);
    check_eq("first_tick", n, 16);
    for (int k = 0; k < 3; k++) begin
      wait_tick(n);
      check_eq("tick_period", n, 16);
    end
    hold(100, "held_ss");
    check_eq("held_no_repeat", int'(state), ST_RUN);
    btn_ss = 1'b0;
    hold(170, "release");

    // Bouncing start/stop gives a single IDLE->RUN.
    apply_reset(3);
    trans_cnt = 0;
    btn_ss = 1'b1; hold(50, "bounce");
    btn_ss = 1'b0; hold(5, "bounce");
    btn_ss = 1'b1; hold(200, "bounce");
    btn_ss = 1'b0; hold(170, "bounce");
    check_eq("bounce_transitions", trans_cnt, 1);
    check_eq("bounce_state", int'(state), ST_RUN);

    // Lap freezes 1.234 while the live count moves, then tracking resumes.
    tmr_sec = 6'd1; tmr_ms = 10'd234;
    btn_clr = 1'b1;
    hold(170, "lap_enter");
    check_eq("lap_state", int'(state), ST_LAP);
    for (int i = 0; i < 200; i++) begin
      tmr_ms = 10'(235 + i);
      if (i == 0) btn_clr = 1'b0;
      cyc("lap_hold");
      if (i % 40 == 39) begin
        check_eq("lap_disp_ms", int'(disp_ms), 234);
        check_eq("lap_disp_sec", int'(disp_sec), 1);
      end
    end
    btn_clr = 1'b1;
    for (int i = 0; i < 180; i++) begin
      tmr_ms = 10'(435 + i);
      if (i == 170) btn_clr = 1'b0;
      cyc("lap_exit");
    end
    check_eq("lap_exit_state", int'(state), ST_RUN);
    for (int j = 0; j < 5; j++) begin
      v = 615 + j;
      tmr_ms = 10'(v);
      cyc("live_track");
      check_eq("live_disp_ms", int'(disp_ms), v);
    end
    tmr_sec = 6'd0; tmr_ms = 10'd0;
    hold(170, "settle");

    // Stop then clear: one clear pulse, no ticks, prescaler restarts from 0.
    press(1'b1, 1'b0, "stop");
    check_eq("stop_state", int'(state), ST_STOP);
    clr_seen = 0; tick_seen = 0;
    press(1'b0, 1'b1, "clear");
    check_eq("clear_state", int'(state), ST_IDLE);
    check_eq("clear_pulses", clr_seen, 1);
    check_eq("clear_no_tick", tick_seen, 0);
    btn_ss = 1'b1;
    wait_start(n);
    check_range("restart_latency", n, 160, 164);
    wait_tick(n);
    check_eq("restart_first_tick", n, 16);
    btn_ss = 1'b0;
    hold(170, "release");

    // Reset mid-RUN: ticks stop, block waits in IDLE.
    hold(7, "pre_reset");
    apply_reset(4);
    tick_seen = 0;
    hold(300, "post_reset");
    check_eq("post_reset_state", int'(state), ST_IDLE);
    check_eq("post_reset_ticks", tick_seen, 0);

    // Button held through reset release still registers one press.
    btn_ss = 1'b1;
    hold(5, "pre_reset_held");
    apply_reset(4);
    wait_start(n);
    check_range("held_reset_latency", n, 160, 164);
    btn_ss = 1'b0;
    hold(170, "release");

    // Overflow at 59.999 on a tick.
    tmr_sec = 6'd59; tmr_ms = 10'd999;
    wait_tick(n);
    check_eq("ovf_tick_seen", int'(en_1ms), 1);
    cyc("ovf_edge");
`ifdef STOPWATCH_CTRL_AUTOSTOP_EN
    check_eq("ovf_state", int'(state), ST_STOP);
    check_eq("ovf_flag", int'(ovf), 1);
    hold(20, "ovf_hold");
    check_eq("ovf_sticky", int'(ovf), 1);
    tmr_sec = 6'd0; tmr_ms = 10'd0;
    press(1'b0, 1'b1, "ovf_clear");
    check_eq("ovf_cleared", int'(ovf), 0);
`else
    check_eq("wrap_state", int'(state), ST_RUN);
    check_eq("wrap_flag", int'(ovf), 0);
    hold(20, "wrap_hold");
    check_eq("wrap_flag_hold", int'(ovf), 0);
    tmr_sec = 6'd0; tmr_ms = 10'd0;
    press(1'b1, 1'b0, "wrap_stop");
    press(1'b0, 1'b1, "wrap_clear");
`endif
    check_eq("ovf_end_state", int'(state), ST_IDLE);

    // Random button activity and timer values against the model.
    for (int r = 0; r < 40; r++) begin
      if (r == 20) apply_reset(2);
      btn_ss  = 1'($urandom_range(0, 1));
      btn_clr = 1'($urandom_range(0, 1));
      dh = $urandom_range(3, 260);
      dl = $urandom_range(3, 260);
      for (int c = 0; c < dh + dl; c++) begin
        if (c == dh) begin
          btn_ss = 1'b0; btn_clr = 1'b0;
        end
        if ($urandom_range(0, 7) == 0) begin
          tmr_sec = 6'd59; tmr_ms = 10'd999;
        end else begin
          tmr_sec = 6'($urandom_range(0, 59));
          tmr_ms  = 10'($urandom_range(0, 999));
        end
        cyc("random");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Overall time bound.
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
